mw_subtractor: RTL and testbench
================================

MW_SUBTRACTOR -- requirements
Module: mw_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand word width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the word-counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_ready  output  1  block accepts an input word this cycle.
REQ-007 in_a  input  WIDTH  minuend word, least-significant word first.
REQ-008 in_b  input  WIDTH  subtrahend word, least-significant word first.
REQ-009 in_first  input  1  marks the least-significant word of an operand pair.
REQ-010 in_last  input  1  marks the most-significant word of an operand pair.
REQ-011 out_valid  output  1  output word present.
REQ-012 out_ready  input  1  downstream accepts the output word.
REQ-013 out_diff  output  WIDTH  difference word.
REQ-014 out_last  output  1  marks the final difference word of an operation.
REQ-015 out_borrow  output  1  final borrow; qualified by out_last, 0 otherwise.
REQ-016 out_zero  output  1  whole multi-word result is zero; qualified by out_last, 0 otherwise.
REQ-017 out_count  output  CNT_W  number of words in the operation; qualified by out_last, 0 otherwise.
REQ-018 seq_err  output  1  one-cycle pulse on a framing error.

Function
REQ-019 An input word SHALL be accepted on a rising edge when in_valid and in_ready are both 1.
REQ-020 in_ready SHALL equal (!out_valid || out_ready), giving a single output register.
REQ-021 Latency SHALL be one cycle: an accepted word appears on out_* at the following edge with out_valid=1.
REQ-022 out_valid SHALL stay 1 and all out_* SHALL stay stable until out_ready=1.
REQ-023 Per accepted word: bin = 0 if the word starts a chain, else borrow_r; {bout, diff} = {1'b0,in_a} - {1'b0,in_b} - bin, all modulo 2^(WIDTH+1).
REQ-024 borrow_r SHALL load bout on a non-last accepted word and clear to 0 on a last accepted word.
REQ-025 A zero accumulator SHALL be reset to 1 at chain start and ANDed with (diff==0) on every accepted word; out_zero SHALL be the accumulated value on the last word.
REQ-026 A word counter SHALL restart at 1 at chain start, increment per accepted word and saturate at 2^CNT_W-1.
REQ-027 The FSM SHALL have two states: IDLE (expects in_first) and RUN (mid-chain).
REQ-028 IDLE->RUN SHALL occur on an accepted word with in_last=0; an accepted first&last word SHALL remain in IDLE.
REQ-029 RUN->IDLE SHALL occur on an accepted word with in_last=1.
REQ-030 An accepted word in IDLE with in_first=0 SHALL pulse seq_err and be treated as a chain start.
REQ-031 An accepted word in RUN with in_first=1 SHALL pulse seq_err and restart the chain (bin=0, counter=1, zero accumulator=1); it SHALL NOT emit a truncated last word for the abandoned chain.
REQ-032 For a chain start, in_first and in_last both 1 SHALL denote a single-word operation.
REQ-033 No state SHALL change while out_valid=1 and out_ready=0.

Reset
REQ-034 While rst_n=0, the FSM SHALL be IDLE, borrow_r=0, the counter=0 and the zero accumulator=1.
REQ-035 While rst_n=0, out_valid, out_diff, out_last, out_borrow, out_zero, out_count and seq_err SHALL all be 0, and in_ready SHALL be 1.
REQ-036 Reset asserted mid-chain SHALL discard the partial chain and any pending output word, with no seq_err pulse.

Verification
REQ-037 The bench SHALL use WIDTH=8 for all scenarios.
REQ-038 Single word a=0x12, b=0x05, first=last=1 -> out_diff=0x0D, out_borrow=0, out_zero=0, out_count=1.
REQ-039 Single word a=0x0A, b=0x0F -> out_diff=0xFB, out_borrow=1, out_zero=0.
REQ-040 Two words 0x0100-0x0001 sent as (0x00,0x01) then (0x01,0x00) -> out_diff 0xFF with out_last=0, then 0x00 with out_last=1, out_borrow=0, out_zero=0, out_count=2.
REQ-041 Two equal words 0xABCD-0xABCD -> out_diff 0x00 then 0x00, out_zero=1, out_borrow=0.
REQ-042 out_ready held 0 for 3 cycles with an output pending -> out_valid stays 1, out_diff stays stable, in_ready=0, no input accepted.
REQ-043 rst_n pulsed low after the first word of a 3-word chain, then a word sent with in_first=0 -> all outputs 0 during reset, then seq_err=1 for one cycle and the word is processed with bin=0.

Source files
------------

// File: rtl/mw_subtractor.sv
// Multi-word serial subtractor: streams operand words LS-first, carries the borrow
// between words and reports final borrow, zero flag and word count on the last word.
module mw_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_last,
    output logic             out_borrow,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_count,
    output logic             seq_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0]       state, state_next;
    logic             borrow_r, borrow_next;
    logic             zero_acc, zero_next;
    logic [CNT_W-1:0] count, count_next;

    logic             accept;
    logic             chain_start;
    logic             frame_err;
    logic             bin;
    logic [WIDTH:0]   sub;
    logic             word_zero;

    // Single output register: a new word may enter whenever the slot drains this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Any word seen in IDLE, or a first-marked word mid-chain, begins a fresh chain.
    assign chain_start = (state == IDLE) || in_first;
    assign frame_err   = (state == IDLE) ? !in_first : in_first;
    assign bin         = chain_start ? 1'b0 : borrow_r;

    assign sub       = {1'b0, in_a} - {1'b0, in_b} - {{WIDTH{1'b0}}, bin};
    assign word_zero = (sub[WIDTH-1:0] == '0);

    always_comb begin
        state_next  = state;
        borrow_next = borrow_r;
        zero_next   = zero_acc;
        count_next  = count;
        if (accept) begin
            state_next  = in_last ? IDLE : RUN;
            borrow_next = in_last ? 1'b0 : sub[WIDTH];
            zero_next   = (chain_start ? 1'b1 : zero_acc) & word_zero;
            if (chain_start) begin
                count_next = CNT_ONE;
            end else if (count != CNT_MAX) begin
                count_next = count + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            borrow_r <= 1'b0;
            zero_acc <= 1'b1;
            count    <= '0;
        end else begin
            state    <= state_next;
            borrow_r <= borrow_next;
            zero_acc <= zero_next;
            count    <= count_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_diff   <= '0;
            out_last   <= 1'b0;
            out_borrow <= 1'b0;
            out_zero   <= 1'b0;
            out_count  <= '0;
            seq_err    <= 1'b0;
        end else begin
            seq_err <= accept && frame_err;
            if (accept) begin
                out_valid  <= 1'b1;
                out_diff   <= sub[WIDTH-1:0];
                out_last   <= in_last;
                out_borrow <= in_last && sub[WIDTH];
                out_zero   <= in_last && zero_next;
                out_count  <= in_last ? count_next : '0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mw_subtractor.sv
// Bench for mw_subtractor: directed literal cases plus randomized framing/backpressure
// checked against a whole-operand arithmetic model.
`timescale 1ns/1ps
module tb_mw_subtractor;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_first;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_diff;
    logic       out_last;
    logic       out_borrow;
    logic       out_zero;
    logic [7:0] out_count;
    logic       seq_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] diff;
        logic       last;
        logic       borrow;
        logic       zero;
        logic [7:0] count;
    } exp_t;

    exp_t expq[$];
    logic err_exp;

    mw_subtractor #(.WIDTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff),
        .out_last  (out_last),
        .out_borrow(out_borrow),
        .out_zero  (out_zero),
        .out_count (out_count),
        .seq_err   (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: rebuild both operands as integers and take slices of their difference.
    initial begin
        logic       in_chain;
        logic [63:0] pa, pb, d;
        int          n;
        logic        acc;
        exp_t        e;
        in_chain = 1'b0;
        pa = '0;
        pb = '0;
        n = 0;
        err_exp = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                expq.delete();
                in_chain = 1'b0;
                err_exp = 1'b0;
                pa = '0;
                pb = '0;
                n = 0;
            end else begin
                acc = in_valid && (expq.size() == 0 || out_ready);
                if (expq.size() != 0 && out_ready) void'(expq.pop_front());
                err_exp = 1'b0;
                if (acc) begin
                    err_exp = in_chain ? in_first : !in_first;
                    if (!in_chain || in_first) begin
                        pa = '0;
                        pb = '0;
                        n = 0;
                    end
                    pa = pa | (64'(in_a) << (8 * n));
                    pb = pb | (64'(in_b) << (8 * n));
                    n++;
                    d = pa - pb;
                    e.diff   = 8'(d >> (8 * (n - 1)));
                    e.last   = in_last;
                    e.borrow = in_last && (pa < pb);
                    e.zero   = in_last && (pa == pb);
                    e.count  = in_last ? ((n > 255) ? 8'd255 : 8'(n)) : 8'd0;
                    expq.push_back(e);
                    in_chain = !in_last;
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_out_diff", 32'(out_diff), 32'd0);
                chk("rst_flags", {28'd0, out_last, out_borrow, out_zero, seq_err}, 32'd0);
                chk("rst_out_count", 32'(out_count), 32'd0);
                chk("rst_in_ready", 32'(in_ready), 32'd1);
            end else begin
                chk("out_valid", 32'(out_valid), 32'(expq.size() != 0));
                chk("in_ready", 32'(in_ready), 32'(expq.size() == 0 || out_ready));
                chk("seq_err", 32'(seq_err), 32'(err_exp));
                if (expq.size() != 0) begin
                    chk("out_diff", 32'(out_diff), 32'(expq[0].diff));
                    chk("out_last", 32'(out_last), 32'(expq[0].last));
                    chk("out_borrow", 32'(out_borrow), 32'(expq[0].borrow));
                    chk("out_zero", 32'(out_zero), 32'(expq[0].zero));
                    chk("out_count", 32'(out_count), 32'(expq[0].count));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic f, input logic l);
        in_a      = a;
        in_b      = b;
        in_first  = f;
        in_last   = l;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int  pos;
        int  len;
        logic acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        send(8'h12, 8'h05, 1'b1, 1'b1);
        chk("s1_diff", 32'(out_diff), 32'h0D);
        chk("s1_borrow", 32'(out_borrow), 32'd0);
        chk("s1_zero", 32'(out_zero), 32'd0);
        chk("s1_count", 32'(out_count), 32'd1);

        send(8'h0A, 8'h0F, 1'b1, 1'b1);
        chk("s2_diff", 32'(out_diff), 32'hFB);
        chk("s2_borrow", 32'(out_borrow), 32'd1);
        chk("s2_zero", 32'(out_zero), 32'd0);

        send(8'h00, 8'h01, 1'b1, 1'b0);
        chk("w2a_diff", 32'(out_diff), 32'hFF);
        chk("w2a_last", 32'(out_last), 32'd0);
        send(8'h01, 8'h00, 1'b0, 1'b1);
        chk("w2b_diff", 32'(out_diff), 32'h00);
        chk("w2b_last", 32'(out_last), 32'd1);
        chk("w2b_borrow", 32'(out_borrow), 32'd0);
        chk("w2b_zero", 32'(out_zero), 32'd0);
        chk("w2b_count", 32'(out_count), 32'd2);

        send(8'hCD, 8'hCD, 1'b1, 1'b0);
        chk("eq_a_diff", 32'(out_diff), 32'h00);
        send(8'hAB, 8'hAB, 1'b0, 1'b1);
        chk("eq_b_diff", 32'(out_diff), 32'h00);
        chk("eq_b_zero", 32'(out_zero), 32'd1);
        chk("eq_b_borrow", 32'(out_borrow), 32'd0);

        // Stall: output pending, downstream not ready, a competing word offered.
        send(8'h30, 8'h10, 1'b1, 1'b1);
        out_ready = 1'b0;
        in_a      = 8'h77;
        in_b      = 8'h11;
        in_first  = 1'b1;
        in_last   = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_diff", 32'(out_diff), 32'h20);
            chk("stall_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("stall_drain", 32'(out_valid), 32'd0);

        // Reset in the middle of a chain, then resume without a first marker.
        send(8'h00, 8'h01, 1'b1, 1'b0);
        chk("mid_diff", 32'(out_diff), 32'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_diff", 32'(out_diff), 32'd0);
        chk("mid_rst_err", 32'(seq_err), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        send(8'h05, 8'h03, 1'b0, 1'b1);
        chk("resume_err", 32'(seq_err), 32'd1);
        chk("resume_diff", 32'(out_diff), 32'h02);
        chk("resume_count", 32'(out_count), 32'd1);
        tick();
        @(negedge clk);
        chk("resume_err_clear", 32'(seq_err), 32'd0);
        tick();

        pos = 0;
        len = $urandom_range(1, 5);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            in_a      = 8'($urandom);
            in_b      = ($urandom_range(0, 3) == 0) ? in_a : 8'($urandom);
            in_first  = (pos == 0);
            in_last   = (pos == len - 1);
            if ($urandom_range(0, 19) == 0) in_first = !in_first;
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                if (in_last) begin
                    pos = 0;
                    len = $urandom_range(1, 5);
                end else begin
                    pos++;
                end
            end
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
